uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, clocks per serial bit; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port data_o  output  8  received byte, valid while we_o=1.
REQ-006 SHALL have port we_o  output  1  single-cycle write strobe into the downstream FIFO.
REQ-007 SHALL have port full_i  input  1  downstream FIFO full.
REQ-008 SHALL have port perr_o  output  1  single-cycle parity-error pulse.
REQ-009 SHALL have port ferr_o  output  1  single-cycle framing-error pulse.
REQ-010 SHALL have port ovf_o  output  1  single-cycle overrun pulse (byte dropped).

Function
REQ-011 SHALL accept frame: start(0), data[0]..data[7] LSB first, parity, stop(1); each bit held CLKS_PER_BIT clocks.
REQ-012 SHALL use odd parity: data bits plus parity bit contain an odd number of ones.
REQ-013 SHALL pass rx through a 2-flop synchronizer, reset value 1; all decoding uses the synchronized value rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE: rx_s=0 -> START and clear bit counter; otherwise stay.
REQ-016 START: wait (CLKS_PER_BIT-1)/2 clocks (0 when CLKS_PER_BIT=1), then sample rx_s: 0 -> DATA, 1 -> IDLE (glitch rejected, no flags).
REQ-017 DATA: sample every CLKS_PER_BIT clocks, shift right into an 8-bit register (MSB in), 3-bit counter; after 8th sample -> PARITY.
REQ-018 PARITY: after CLKS_PER_BIT clocks sample parity bit -> STOP.
REQ-019 STOP: after CLKS_PER_BIT clocks sample stop bit -> IDLE; completion actions occur in the cycle after the stop sample.
REQ-020 Completion, stop=1, full_i=0: we_o=1 one cycle, data_o=byte; perr_o=1 same cycle if parity wrong; byte written regardless of parity.
REQ-021 Completion, stop=1, full_i=1: we_o stays 0, ovf_o=1 one cycle, perr_o as REQ-020; byte lost.
REQ-022 Completion, stop=0: ferr_o=1 one cycle, we_o=0, perr_o=0; return to IDLE and require rx_s=1 for at least one sample before a new start is accepted.
REQ-023 full_i SHALL be sampled only in the completion cycle; the receiver SHALL never stall the line.
REQ-024 data_o SHALL hold the last completed byte until the next completion.
REQ-025 Back-to-back frames separated by one idle bit SHALL be received without loss.
REQ-026 With CLKS_PER_BIT=1, SHALL decode one bit per clock, compatible with the team's uart_tx frame (which holds the line high at least 3 clocks between frames).

Reset
REQ-027 rst=1 at a clock edge: state=IDLE; counters=0; shift register=0x00; data_o=0x00; we_o, perr_o, ferr_o, ovf_o=0; synchronizer flops=1.
REQ-028 Reset mid-frame SHALL abandon the frame with no strobes; the remaining bits of the interrupted frame SHALL not produce a write (line must return high before the next start).

Verification
REQ-029 CLKS_PER_BIT=1, send 0xA5, parity 1, stop 1, full_i=0 -> one we_o pulse, data_o=0xA5, no error flags.
REQ-030 Send 0x01 with parity 1 (wrong) -> we_o=1, data_o=0x01, perr_o=1 same cycle.
REQ-031 Send 0x3C with stop bit 0 -> ferr_o=1, we_o=0; next frame 0xFF parity 1 -> data_o=0xFF.
REQ-032 full_i=1 during completion of 0x55 -> ovf_o=1, we_o=0, data_o keeps previous value.
REQ-033 CLKS_PER_BIT=16, 1-clock low glitch on idle line -> no strobes; then 0x00 parity 1 -> data_o=0x00, we_o once.
REQ-034 Drive rst for 1 clock during DATA of 0x96 -> no strobes; next frame 0x69 parity 1 -> data_o=0x69.

Source files
------------

// File: rtl/uart_rx.sv
// 8-bit UART receiver: start, 8 data bits LSB first, odd parity, one stop bit.
// Completed bytes are offered to a downstream FIFO as a one-cycle write strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       we_o,
  input  logic       full_i,
  output logic       perr_o,
  output logic       ferr_o,
  output logic       ovf_o
);

  localparam logic [7:0]  HALF  = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0]  LAST  = 8'(CLKS_PER_BIT - 1);
  // Longest run of ones an interrupted frame can still put on the line,
  // plus the two synchronizer stages that come out of reset high.
  localparam logic [11:0] QUIET = 12'(11 * CLKS_PER_BIT + 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q, rx_dly_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d;
  logic [11:0] quiet_q, quiet_d;
  logic        long_q, long_d;
  logic        done_q, done_d;
  logic        stop_ok_q, stop_ok_d;
  logic        perr_q, perr_d;
  logic [7:0]  data_q, data_d;

  // rx_dly_q trails rx_s_q by one clock so the start-bit check can look back
  // at the very sample that left IDLE when no wait is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_dly_q  <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_dly_q  <= rx_s_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    par_d     = par_q;
    quiet_d   = quiet_q;
    long_d    = long_q;
    done_d    = 1'b0;
    stop_ok_d = stop_ok_q;
    perr_d    = perr_q;
    data_d    = we_o ? sh_q : data_q;
    unique case (state_q)
      IDLE: begin
        if (quiet_q != 12'd0) begin
          if (rx_s_q)      quiet_d = quiet_q - 12'd1;
          else if (long_q) quiet_d = QUIET;
        end else if (!rx_s_q) begin
          state_d = START;
          cnt_d   = 8'd0;
          bit_d   = 3'd0;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = 8'd0;
          state_d = rx_dly_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = 8'd0;
          sh_d  = {rx_dly_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = 8'd0;
          par_d   = rx_dly_q;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d     = 8'd0;
          done_d    = 1'b1;
          stop_ok_d = rx_dly_q;
          perr_d    = ~(^{sh_q, par_q});
          state_d   = IDLE;
          if (!rx_dly_q) begin
            quiet_d = 12'd1;
            long_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      bit_q     <= 3'd0;
      sh_q      <= 8'd0;
      par_q     <= 1'b0;
      quiet_q   <= QUIET;
      long_q    <= 1'b1;
      done_q    <= 1'b0;
      stop_ok_q <= 1'b0;
      perr_q    <= 1'b0;
      data_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      quiet_q   <= quiet_d;
      long_q    <= long_d;
      done_q    <= done_d;
      stop_ok_q <= stop_ok_d;
      perr_q    <= perr_d;
      data_q    <= data_d;
    end
  end

  // full_i only matters in the completion cycle, so the strobes stay combinational.
  assign we_o   = done_q & stop_ok_q & ~full_i;
  assign ovf_o  = done_q & stop_ok_q & full_i;
  assign perr_o = done_q & stop_ok_q & perr_q;
  assign ferr_o = done_q & ~stop_ok_q;
  assign data_o = we_o ? sh_q : data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one receiver at 1 clock per bit, one at 16.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst1, rx1, full1, we1, perr1, ferr1, ovf1;
  logic       rst16, rx16, full16, we16, perr16, ferr16, ovf16;
  logic [7:0] data1, data16;

  int total = 0;
  int bad   = 0;

  int we1_n = 0, perr1_n = 0, pw1_n = 0, ferr1_n = 0, ovf1_n = 0;
  int we16_n = 0, perr16_n = 0, ferr16_n = 0, ovf16_n = 0;
  logic [7:0] last1 = 8'h00, prev1 = 8'h00, last16 = 8'h5A;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst1), .rx(rx1), .data_o(data1), .we_o(we1),
    .full_i(full1), .perr_o(perr1), .ferr_o(ferr1), .ovf_o(ovf1)
  );

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst(rst16), .rx(rx16), .data_o(data16), .we_o(we16),
    .full_i(full16), .perr_o(perr16), .ferr_o(ferr16), .ovf_o(ovf16)
  );

  // Pulse counters, sampled mid-cycle after outputs have settled.
  always @(posedge clk) begin
    #2;
    if (we1) begin we1_n++; prev1 = last1; last1 = data1; end
    if (perr1) perr1_n++;
    if (perr1 && we1) pw1_n++;
    if (ferr1) ferr1_n++;
    if (ovf1) ovf1_n++;
    if (we16) begin we16_n++; last16 = data16; end
    if (perr16) perr16_n++;
    if (ferr16) ferr16_n++;
    if (ovf16) ovf16_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting at a falling clock edge; rst_bit >= 0 pulses
  // the receiver's reset for one clock at the start of that bit.
  task automatic send(input int which, input logic [7:0] d, input logic p,
                      input logic s, input int rst_bit);
    logic [10:0] fr;
    int cpb;
    fr  = {s, p, d, 1'b0};
    cpb = (which == 1) ? 1 : 16;
    for (int i = 0; i < 11; i++) begin
      if (which == 1) rx1 = fr[i]; else rx16 = fr[i];
      if (i == rst_bit) begin
        if (which == 1) rst1 = 1'b1; else rst16 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        rst16 = 1'b0;
        repeat (cpb - 1) @(negedge clk);
      end else begin
        repeat (cpb) @(negedge clk);
      end
    end
  endtask

  task automatic idle1(input int n);
    rx1 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rx1 = 1'b1; rx16 = 1'b1; full1 = 1'b0; full16 = 1'b0;
    rst1 = 1'b1; rst16 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data1", 32'(data1), 32'h00);
    chk("rst_we1",   32'(we1),   32'h0);
    chk("rst_perr1", 32'(perr1), 32'h0);
    chk("rst_ferr1", 32'(ferr1), 32'h0);
    chk("rst_ovf1",  32'(ovf1),  32'h0);
    chk("rst_data16", 32'(data16), 32'h00);
    rst1 = 1'b0; rst16 = 1'b0;
    idle1(20);

    // 0xA5, correct parity
    send(1, 8'hA5, 1'b1, 1'b1, -1);
    idle1(8);
    chk("a5_we",   32'(we1_n),   32'd1);
    chk("a5_data", 32'(last1),   32'hA5);
    chk("a5_perr", 32'(perr1_n), 32'd0);
    chk("a5_ferr", 32'(ferr1_n), 32'd0);
    chk("a5_ovf",  32'(ovf1_n),  32'd0);

    // 0x01 with wrong parity: still written, perr alongside we
    send(1, 8'h01, 1'b1, 1'b1, -1);
    idle1(8);
    chk("p01_we",    32'(we1_n),   32'd2);
    chk("p01_data",  32'(last1),   32'h01);
    chk("p01_perr",  32'(perr1_n), 32'd1);
    chk("p01_pw",    32'(pw1_n),   32'd1);

    // 0x3C with stop bit 0, then 0xFF
    send(1, 8'h3C, 1'b1, 1'b0, -1);
    idle1(8);
    chk("f3c_ferr", 32'(ferr1_n), 32'd1);
    chk("f3c_we",   32'(we1_n),   32'd2);
    chk("f3c_perr", 32'(perr1_n), 32'd1);
    send(1, 8'hFF, 1'b1, 1'b1, -1);
    idle1(8);
    chk("ff_we",   32'(we1_n), 32'd3);
    chk("ff_data", 32'(last1), 32'hFF);

    // 0x55 into a full FIFO: dropped, data_o holds 0xFF
    full1 = 1'b1;
    send(1, 8'h55, 1'b1, 1'b1, -1);
    idle1(8);
    chk("o55_ovf",  32'(ovf1_n), 32'd1);
    chk("o55_we",   32'(we1_n),  32'd3);
    chk("o55_hold", 32'(data1),  32'hFF);
    full1 = 1'b0;
    idle1(2);

    // back-to-back frames with a single idle bit
    send(1, 8'h12, 1'b1, 1'b1, -1);
    idle1(1);
    send(1, 8'h34, 1'b0, 1'b1, -1);
    idle1(8);
    chk("b2b_we",    32'(we1_n),   32'd5);
    chk("b2b_first", 32'(prev1),   32'h12);
    chk("b2b_last",  32'(last1),   32'h34);
    chk("b2b_perr",  32'(perr1_n), 32'd1);

    // reset in the middle of 0x96, then 0x69
    send(1, 8'h96, 1'b1, 1'b1, 5);
    idle1(20);
    chk("r96_we",   32'(we1_n),   32'd5);
    chk("r96_ferr", 32'(ferr1_n), 32'd1);
    chk("r96_data", 32'(data1),   32'h00);
    send(1, 8'h69, 1'b1, 1'b1, -1);
    idle1(8);
    chk("r69_we",   32'(we1_n),   32'd6);
    chk("r69_data", 32'(last1),   32'h69);
    chk("r69_err",  32'(perr1_n + ferr1_n + ovf1_n), 32'd3);

    // 16 clocks per bit: one-clock glitch, then 0x00
    repeat (200) @(negedge clk);
    rx16 = 1'b0;
    @(negedge clk);
    rx16 = 1'b1;
    repeat (60) @(negedge clk);
    chk("g16_we",  32'(we16_n), 32'd0);
    chk("g16_err", 32'(perr16_n + ferr16_n + ovf16_n), 32'd0);
    send(16, 8'h00, 1'b1, 1'b1, -1);
    repeat (40) @(negedge clk);
    chk("z16_we",   32'(we16_n), 32'd1);
    chk("z16_data", 32'(last16), 32'h00);
    chk("z16_err",  32'(perr16_n + ferr16_n + ovf16_n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
